// File: rtl/clk_gen_pkg.sv
// Shared definitions for the programmable clock generator.
//   - state_t       : controller states (STOP, RUN, PEND)
//   - CNT_W_DEF     : default half-period counter width
//   - DEF_HALF_DEF  : default half-period loaded at reset
//   - clamp1()      : forces a zero length to one
package clk_gen_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int DEF_HALF_DEF = 5;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // A phase length of zero has no meaning; treat it as the shortest phase.
  function automatic logic [31:0] clamp1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/clk_gen_phase_cnt.sv
// Phase counter for the clock generator.
// Counts clk cycles within the current phase of clk_out and toggles clk_out
// when the phase length is reached. Emits one-cycle rise/fall strobes that
// are registered on the same edge as the toggle.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   i_run        : 1 = count, 0 = idle (counter cleared, clk_out held low)
//   i_hi_len     : high-phase length in clk cycles (>= 1)
//   i_lo_len     : low-phase length in clk cycles (>= 1)
//   o_clk_out    : generated clock (registered)
//   o_rise       : strobe, clk_out just went 0->1
//   o_fall       : strobe, clk_out just went 1->0
//   o_fall_tc    : combinational, a falling toggle happens at the next edge
module clk_gen_phase_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_hi_len,
  input  logic [CNT_W-1:0] i_lo_len,
  output logic             o_clk_out,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_fall_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_out;
  logic             r_rise;
  logic             r_fall;

  logic [CNT_W-1:0] w_len;
  logic             w_tc;

  // Length of the phase we are currently in.
  assign w_len     = r_clk_out ? i_hi_len : i_lo_len;
  assign w_tc      = i_run && (r_cnt == (w_len - CNT_W'(1)));
  assign o_fall_tc = w_tc && r_clk_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else if (!i_run) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else if (w_tc) begin
      r_cnt     <= '0;
      r_clk_out <= ~r_clk_out;
      r_rise    <= ~r_clk_out;
      r_fall    <= r_clk_out;
    end else begin
      r_cnt     <= r_cnt + CNT_W'(1);
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;

endmodule

// File: rtl/clk_gen_ctrl.sv
// Programmable clock generator / controller.
// Produces clk_out from clk with a programmable half-period. New settings
// arrive over a valid/ready handshake; while running, a new setting is held
// in a shadow register and applied only at the falling edge of clk_out, so
// clk_out never shows a shortened phase.
// Optional build macro CLKGEN_DUTY_EN: adds cfg_lo / cur_lo so the low phase
// length is programmed independently of the high phase.
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   cfg_valid/cfg_ready : config handshake (transfer when both high)
//   cfg_half            : requested half-period (high phase), 0 clamps to 1
//   cfg_en              : 1 = run, 0 = stop
//   cfg_lo  (macro)     : requested low phase length, 0 clamps to 1
//   clk_out             : generated clock
//   rise_pulse          : one-cycle strobe with clk_out 0->1
//   fall_pulse          : one-cycle strobe with clk_out 1->0
//   busy                : a shadowed config is waiting for its boundary
//   cur_half            : half-period in effect
//   cur_lo  (macro)     : low phase length in effect
module clk_gen_ctrl
  import clk_gen_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_HALF = DEF_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half,
`ifdef CLKGEN_DUTY_EN
  input  logic [CNT_W-1:0] cfg_lo,
  output logic [CNT_W-1:0] cur_lo,
`endif
  input  logic             cfg_en,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cur_half;
  logic [CNT_W-1:0] r_sh_half;
  logic             r_sh_en;

  logic             w_accept;
  logic             w_ld_cur;
  logic             w_cur_from_sh;
  logic             w_ld_sh;
  logic             w_fall_tc;
  logic             w_run;
  logic [CNT_W-1:0] w_half_cl;
  logic [CNT_W-1:0] w_lo_len;

  assign w_half_cl = CNT_W'(clamp1(32'(cfg_half)));
  assign cfg_ready = (r_state != PEND);
  assign busy      = (r_state == PEND);
  assign w_accept  = cfg_valid && cfg_ready;
  assign w_run     = (r_state != STOP);

`ifdef CLKGEN_DUTY_EN
  logic [CNT_W-1:0] r_cur_lo;
  logic [CNT_W-1:0] r_sh_lo;
  logic [CNT_W-1:0] w_lo_cl;

  assign w_lo_cl  = CNT_W'(clamp1(32'(cfg_lo)));
  assign w_lo_len = r_cur_lo;
  assign cur_lo   = r_cur_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_lo <= CNT_W'(DEF_HALF);
    end else if (w_ld_cur) begin
      r_cur_lo <= w_cur_from_sh ? r_sh_lo : w_lo_cl;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_sh) begin
      r_sh_lo <= w_lo_cl;
    end
  end
`else
  assign w_lo_len = r_cur_half;
`endif

  // Next state and register load enables.
  always_comb begin
    w_state_nxt   = r_state;
    w_ld_cur      = 1'b0;
    w_cur_from_sh = 1'b0;
    w_ld_sh       = 1'b0;
    case (r_state)
      STOP: begin
        if (w_accept) begin
          w_ld_cur = 1'b1;
          if (cfg_en) begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (w_accept) begin
          w_ld_sh     = 1'b1;
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        // Only the falling toggle is a safe boundary: clk_out is then low
        // and the counter restarts, so the new lengths start a clean phase.
        if (w_fall_tc) begin
          w_ld_cur      = 1'b1;
          w_cur_from_sh = 1'b1;
          w_state_nxt   = r_sh_en ? RUN : STOP;
        end
      end
      default: w_state_nxt = STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= STOP;
      r_cur_half <= CNT_W'(DEF_HALF);
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_cur) begin
        r_cur_half <= w_cur_from_sh ? r_sh_half : w_half_cl;
      end
    end
  end

  // Shadow holds data only; its content is meaningful only while in PEND.
  always_ff @(posedge clk) begin
    if (w_ld_sh) begin
      r_sh_half <= w_half_cl;
      r_sh_en   <= cfg_en;
    end
  end

  clk_gen_phase_cnt #(
    .CNT_W(CNT_W)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .i_hi_len (r_cur_half),
    .i_lo_len (w_lo_len),
    .o_clk_out(clk_out),
    .o_rise   (rise_pulse),
    .o_fall   (fall_pulse),
    .o_fall_tc(w_fall_tc)
  );

  assign cur_half = r_cur_half;

endmodule
